// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and helpers for the FIFO push arbiter.
//   - word_t      : default-width data word
//   - arb_state_e : arbiter FSM states
//   - next_rr     : circular round-robin search returning a one-hot pick
package fifo_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int DEF_WIDTH = 32;

  typedef logic [DEF_WIDTH-1:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Searches ptr+1, ptr+2, ... (mod n) and returns the first active requester
  // as a one-hot vector. The requester at ptr itself is visited last, so a
  // releasing owner only wins again when nobody else is asking.
  function automatic logic [MAX_REQ-1:0] next_rr(input logic [MAX_REQ-1:0] req,
                                                  input logic [2:0]         ptr,
                                                  input int                 n);
    logic [MAX_REQ-1:0] onehot;
    int                 idx;
    onehot = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k <= n) && (onehot == '0) && req[idx[2:0]]) onehot[idx[2:0]] = 1'b1;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational circular priority picker.
//   req    : request vector
//   ptr    : index of the last winner; search starts just after it
//   onehot : selected requester (zero when none)
//   found  : at least one requester was selected
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic             found
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign pick   = next_rr(req_ext, 3'(ptr), N);
  assign onehot = pick[N-1:0];
  // Bits above N are always zero, so reducing the whole vector is equivalent.
  assign found  = |pick;

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Shares one FIFO push port among NUM_REQ producers with round-robin,
//   bounded-burst arbitration, and gates the consumer pop with FIFO empty.
//   clk, reset          : clock, asynchronous active-high reset
//   req, req_data       : producer valids and packed words (i at [i*WIDTH +: WIDTH])
//   gnt                 : registered one-hot (or zero) grant
//   fifo_push/data_in   : to the FIFO write side
//   fifo_full/empty     : FIFO status
//   pop_req             : consumer read request
//   fifo_pop, pop_valid : to the FIFO read side / consumer data-valid
//   stall_cnt           : saturating count of blocked transfer cycles
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int STALL_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  input  logic                     pop_req,
  output logic                     fifo_pop,
  output logic                     pop_valid,
  output logic [STALL_W-1:0]       stall_cnt
);

  localparam int                  IDX_W     = $clog2(NUM_REQ);
  localparam int                  BEAT_W    = 4;
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]    PTR_RESET = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_reg;
  logic [NUM_REQ-1:0]  gnt_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [STALL_W-1:0]  stall_cnt_reg;

  logic [WIDTH-1:0]    req_word [NUM_REQ];
  logic [IDX_W-1:0]    owner_idx;
  logic [IDX_W-1:0]    pick_ptr;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                pick_found;
  logic                owner_req;
  logic                push_block;
  logic                xfer;
  logic                release_burst;
  logic                stalled;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Pop path: zero latency, never pops an empty FIFO.
  assign fifo_pop   = pop_req && !fifo_empty;
  assign pop_valid  = fifo_pop;

  // A full FIFO can still accept a word when a pop frees a slot this cycle.
  assign push_block = fifo_full && !fifo_pop;
  assign owner_req  = |(gnt_reg & req);
  assign xfer       = owner_req && !push_block;
  assign fifo_push  = xfer;
  assign stalled    = (|gnt_reg) && owner_req && push_block;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_reg[i]) owner_idx = IDX_W'(i);
    end
  end

  // AND-OR mux over the one-hot grant; zero when nothing is granted.
  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_reg[i]) fifo_data_in = fifo_data_in | req_word[i];
    end
  end

  // One picker serves both decisions: from IDLE the search starts after the
  // last released owner, during a burst it starts after the current owner.
  assign pick_ptr = (state_reg == IDLE) ? rr_ptr_reg : owner_idx;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .found  (pick_found)
  );

  assign release_burst = (state_reg == BURST) &&
                         ((xfer && (beat_cnt_reg == LAST_BEAT)) || !owner_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      beat_cnt_reg  <= '0;
      rr_ptr_reg    <= PTR_RESET;
      stall_cnt_reg <= '0;
    end else begin
      if (stalled && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);

      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            gnt_reg      <= pick_onehot;
            beat_cnt_reg <= '0;
            state_reg    <= BURST;
          end
        end
        BURST: begin
          if (release_burst) begin
            rr_ptr_reg   <= owner_idx;
            beat_cnt_reg <= '0;
            if (pick_found) begin
              gnt_reg <= pick_onehot;
            end else begin
              gnt_reg   <= '0;
              state_reg <= IDLE;
            end
          end else if (xfer) begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
          end
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign stall_cnt = stall_cnt_reg;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_reg));
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
                                   !(fifo_push && fifo_full && !fifo_pop));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
                                   !(fifo_pop && fifo_empty));

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;
  localparam int STALL_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     fifo_push;
  logic [WIDTH-1:0]         fifo_data_in;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop_req;
  logic                     fifo_pop;
  logic                     pop_valid;
  logic [STALL_W-1:0]       stall_cnt;

  int checks = 0;
  int errors = 0;

  fifo_push_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST),
    .STALL_W   (STALL_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_push    (fifo_push),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .pop_req      (pop_req),
    .fifo_pop     (fifo_pop),
    .pop_valid    (pop_valid),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic               full;
    logic               empty;
    logic               pop_req;
    logic [NUM_REQ-1:0] exp_gnt;
    logic               exp_push;
    logic               exp_pop;
    logic [STALL_W-1:0] exp_stall;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic r, input logic [3:0] rq, input logic f, input logic e,
                     input logic p, input logic [3:0] g, input logic pu, input logic po,
                     input logic [2:0] s);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.empty = e; v.pop_req = p;
    v.exp_gnt = g; v.exp_push = pu; v.exp_pop = po; v.exp_stall = s;
    vecs.push_back(v);
  endtask

  function automatic logic [WIDTH-1:0] word_of(input int k, input int step);
    return 32'hA000_0000 | (32'(k) << 8) | 32'(step & 8'hff);
  endfunction

  task automatic drive_data(input int step);
    for (int k = 0; k < NUM_REQ; k++) req_data[k*WIDTH +: WIDTH] = word_of(k, step);
  endtask

  function automatic logic [WIDTH-1:0] exp_data_of(input logic [NUM_REQ-1:0] g, input int step);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < NUM_REQ; k++) if (g[k]) d = word_of(k, step);
    return d;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    bit seen;

    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; fifo_empty = 1'b1; pop_req = 1'b0;

    // Single requester: 4-beat burst, re-grant to itself without a bubble.
    add(1, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 0, 1, 0, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b0001, 0, 1, 0, 4'b0001, 1, 0, 0);
    add(0, 4'b0000, 0, 1, 0, 4'b0001, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 0);
    // All four requesting: rotation 1,2,3,0,1 (rr_ptr left at 0).
    add(0, 4'b1111, 0, 1, 0, 4'b0000, 0, 0, 0);
    for (int o = 1; o <= 4; o++)
      for (int b = 0; b < 4; b++) add(0, 4'b1111, 0, 1, 0, 4'(1 << (o % 4)), 1, 0, 0);
    add(0, 4'b1111, 0, 1, 0, 4'b0010, 1, 0, 0);
    add(0, 4'b0000, 0, 1, 0, 4'b0010, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 0);
    // Stall while full: beat count survives, stall_cnt counts and saturates.
    add(1, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0101, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0101, 0, 1, 0, 4'b0001, 1, 0, 0);
    for (int s = 0; s < 5; s++) add(0, 4'b0101, 1, 0, 0, 4'b0001, 0, 0, 3'(s));
    for (int i = 0; i < 3; i++) add(0, 4'b0101, 0, 0, 0, 4'b0001, 1, 0, 5);
    add(0, 4'b0101, 0, 0, 0, 4'b0100, 1, 0, 5);
    // Push and pop together at full.
    add(0, 4'b0100, 1, 0, 1, 4'b0100, 1, 1, 5);
    add(0, 4'b0100, 1, 0, 1, 4'b0100, 1, 1, 5);
    add(0, 4'b0100, 1, 0, 0, 4'b0100, 0, 0, 5);
    add(0, 4'b0100, 1, 0, 0, 4'b0100, 0, 0, 6);
    add(0, 4'b0100, 1, 0, 0, 4'b0100, 0, 0, 7);
    add(0, 4'b0100, 1, 0, 0, 4'b0100, 0, 0, 7);
    // Pop gated by empty.
    add(0, 4'b0000, 0, 1, 1, 4'b0100, 0, 0, 7);
    add(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 7);
    // Reset mid-burst of owner 3, then producer 0 wins first.
    add(0, 4'b1000, 0, 0, 0, 4'b0000, 0, 0, 7);
    add(0, 4'b1000, 0, 0, 0, 4'b1000, 1, 0, 7);
    add(0, 4'b1000, 0, 0, 0, 4'b1000, 1, 0, 7);
    add(1, 4'b1001, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1001, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1001, 0, 0, 0, 4'b0001, 1, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; req = vecs[i].req; fifo_full = vecs[i].full;
      fifo_empty = vecs[i].empty; pop_req = vecs[i].pop_req;
      drive_data(i);
      #1;
      check("gnt", i, 32'(gnt), 32'(vecs[i].exp_gnt));
      check("fifo_push", i, 32'(fifo_push), 32'(vecs[i].exp_push));
      check("fifo_pop", i, 32'(fifo_pop), 32'(vecs[i].exp_pop));
      check("pop_valid", i, 32'(pop_valid), 32'(vecs[i].exp_pop));
      check("fifo_data_in", i, fifo_data_in, exp_data_of(vecs[i].exp_gnt, i));
      check("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].exp_stall));
      $display("vec %0d rst=%b req=%b full=%b empty=%b pop_req=%b -> gnt=%b push=%b pop=%b data=%h stall=%0d",
               i, reset, req, fifo_full, fifo_empty, pop_req, gnt, fifo_push, fifo_pop,
               fifo_data_in, stall_cnt);
    end

    // Owner 0 drops req: grant moves to producer 1 (bounded wait).
    @(negedge clk);
    reset = 1'b0; req = 4'b0010; fifo_full = 1'b0; fifo_empty = 1'b1; pop_req = 1'b0;
    drive_data(99);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk); #1;
      if (gnt == 4'b0010) seen = 1'b1;
    end
    check("handoff_seen", 0, 32'(seen), 32'd1);
    check("handoff_data", 0, fifo_data_in, word_of(1, 99));
    $display("seq handoff gnt=%b push=%b data=%h", gnt, fifo_push, fifo_data_in);

    // Reset asserted between edges must clear the grant with no clock edge.
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_gnt", 0, 32'(gnt), 32'd0);
    check("async_rst_push", 0, 32'(fifo_push), 32'd0);
    $display("seq async reset gnt=%b push=%b", gnt, fifo_push);

    // After reset the search starts after NUM_REQ-1: producer 1 beats 3.
    @(negedge clk);
    reset = 1'b0; req = 4'b1010;
    @(negedge clk); #1;
    check("post_rst_gnt", 0, 32'(gnt), 32'b0010);
    check("post_rst_data", 0, fifo_data_in, word_of(1, 99));
    $display("seq post reset gnt=%b push=%b", gnt, fifo_push);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
